serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/fa_cell.sv | 19 +
 rtl/half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 95 +++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Full-adder cell composed of two half-adders; the two partial carries can never both be set, so OR merges them.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Basic half-adder cell, the building block for the full-adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands shift out LSB first through one shared full-adder cell,
// result bits shift into the sum register from the MSB side; done pulses once the last bit is in.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             cell_s;
  logic             cell_c;

  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (cell_s),
    .cout(cell_c)
  );

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (count == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Written as shift-then-overwrite so a 1-bit sum register needs no special case.
  always_comb begin
    sum_shift            = sum >> 1;
    sum_shift[WIDTH-1]   = cell_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            count <= '0;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= sum_shift;
          carry <= cell_c;
          count <= count + CNT_W'(1);
          if (count == LAST_BIT) cout <= cell_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and table-driven checks of serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, busy8, done8;
  logic       start1;
  logic [0:0] a1, b1, sum1;
  logic       cout1, busy1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Launch one 8-bit add, scramble the operand inputs right after acceptance,
  // then wait (bounded) for done while counting latency and busy cycles.
  task automatic applyStimulus8(input logic [7:0] ia, input logic [7:0] ib,
                                output int lat, output int busy_cyc);
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ia; b8 = ~ib;
    lat = 0;
    busy_cyc = busy8 ? 1 : 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy8) busy_cyc++;
    end
  endtask

  task automatic applyStimulus1(input logic ia, input logic ib, output int lat);
    @(negedge clk);
    a1 = ia; b1 = ib; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = ~ia; b1 = ~ib;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bcyc, seen;
    logic [7:0] ra, rb;
    logic [8:0] exp9;

    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 8'h02, 8'h03, 1'b0};

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sum8",  sum8,  0);
    checkOutput("rst_cout8", cout8, 0);
    checkOutput("rst_busy8", busy8, 0);
    checkOutput("rst_done8", done8, 0);
    checkOutput("rst_busy1", busy1, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus8(vecs[i].a, vecs[i].b, lat, bcyc);
      checkOutput($sformatf("vec%0d_lat", i),  lat,   8);
      checkOutput($sformatf("vec%0d_sum", i),  sum8,  vecs[i].sum);
      checkOutput($sformatf("vec%0d_cout", i), cout8, vecs[i].cout);
      checkOutput($sformatf("vec%0d_busy_cycles", i), bcyc, 9);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_fall", i), done8, 0);
      checkOutput($sformatf("vec%0d_idle", i),      busy8, 0);
    end

    // Result must hold in IDLE while inputs wiggle and start stays low.
    a8 = 8'hC3; b8 = 8'h3C;
    repeat (3) @(negedge clk);
    checkOutput("hold_sum",  sum8,  8'h03);
    checkOutput("hold_cout", cout8, 0);

    // start held high with operands changing every cycle during the add.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 20) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    checkOutput("held_lat",  lat,   8);
    checkOutput("held_sum",  sum8,  8'h46);
    checkOutput("held_cout", cout8, 0);
    a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    checkOutput("held_done_fall", done8, 0);
    checkOutput("held_no_queue",  busy8, 0);
    a8 = 8'h20; b8 = 8'h22;
    @(negedge clk);
    checkOutput("held_reaccept", busy8, 1);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("held2_lat",  lat,   8);
    checkOutput("held2_sum",  sum8,  8'h42);
    checkOutput("held2_cout", cout8, 0);
    @(negedge clk);

    // Reset in the middle of an add, after a result with cout=1 is showing.
    applyStimulus8(8'hFF, 8'hFF, lat, bcyc);
    checkOutput("pre_rst_sum", sum8, 8'hFE);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy8, 0);
    checkOutput("midrst_sum",  sum8,  0);
    checkOutput("midrst_cout", cout8, 0);
    checkOutput("midrst_done", done8, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    checkOutput("midrst_no_done", seen, 0);
    applyStimulus8(8'h01, 8'h02, lat, bcyc);
    checkOutput("post_rst_lat", lat,  8);
    checkOutput("post_rst_sum", sum8, 8'h03);
    @(negedge clk);

    // Single-bit configuration.
    applyStimulus1(1'b1, 1'b1, lat);
    checkOutput("w1_11_lat",  lat,   1);
    checkOutput("w1_11_sum",  sum1,  0);
    checkOutput("w1_11_cout", cout1, 1);
    @(negedge clk);
    checkOutput("w1_done_fall", done1, 0);
    applyStimulus1(1'b1, 1'b0, lat);
    checkOutput("w1_10_lat",  lat,   1);
    checkOutput("w1_10_sum",  sum1,  1);
    checkOutput("w1_10_cout", cout1, 0);
    @(negedge clk);
    applyStimulus1(1'b0, 1'b0, lat);
    checkOutput("w1_00_sum",  sum1,  0);
    checkOutput("w1_00_cout", cout1, 0);
    @(negedge clk);

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp9 = {1'b0, ra} + {1'b0, rb};
      applyStimulus8(ra, rb, lat, bcyc);
      checkOutput($sformatf("rand%0d_%02h_%02h", k, ra, rb), {cout8, sum8}, exp9);
      if (lat != 8) checkOutput($sformatf("rand%0d_lat", k), lat, 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
